// File: rtl/tmr_fault_injector.sv
`default_nettype none
// ============================================================================
// Module   : tmr_fault_injector
// Brief    : Programmable single-replica fault source placed between the three
//            replica result buses and the TMR majority voter. Pass-through
//            when idle; corrupts one bit of one replica during a campaign.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_fault_injector #(
  parameter int          WIDTH     = 32,
  parameter int          DELAY_W   = 16,
  parameter int          DUR_W     = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE11234
) (
  input  logic                     clk,
  input  logic                     sys_reset_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [1:0]               replica_sel_i,
  input  logic [1:0]               mode_i,
  input  logic [$clog2(WIDTH)-1:0] bit_sel_i,
  input  logic                     random_bit_i,
  input  logic [DELAY_W-1:0]       delay_i,
  input  logic [DUR_W-1:0]         duration_i,
  input  logic [WIDTH-1:0]         A_i,
  input  logic [WIDTH-1:0]         B_i,
  input  logic [WIDTH-1:0]         C_i,
  output logic [WIDTH-1:0]         A_o,
  output logic [WIDTH-1:0]         B_o,
  output logic [WIDTH-1:0]         C_o,
  output logic                     busy_o,
  output logic                     fault_active_o,
  output logic                     done_o,
  output logic [15:0]              inject_count_o
);

  localparam int          BIT_W     = $clog2(WIDTH);
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_INJECT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0]   dcnt_q, dcnt_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [1:0]         tgt_q, tgt_d;
  logic [1:0]         mode_q, mode_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [1:0]         rot_q, rot_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [15:0]        count_q, count_d;
  logic               busy_q, busy_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               enter_inject;

  // Corrupt a replica word according to the latched mode and bit mask.
  function automatic logic [WIDTH-1:0] corrupt(input logic [WIDTH-1:0] x,
                                               input logic [1:0]       mode,
                                               input logic [BIT_W-1:0] bidx);
    logic [WIDTH-1:0] mask;
    mask       = '0;
    mask[bidx] = 1'b1;
    case (mode)
      2'd1:    corrupt = x & ~mask;
      2'd2:    corrupt = x | mask;
      default: corrupt = x ^ mask;
    endcase
  endfunction

  // Campaign sequencing, LFSR advance and injection counter next-state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    dur_d        = dur_q;
    tgt_d        = tgt_q;
    mode_d       = mode_q;
    bit_d        = bit_q;
    rot_d        = rot_q;
    count_d      = count_q;
    enter_inject = 1'b0;
    // Right-shifting Galois form: feedback taps applied when the LSB falls out.
    lfsr_d       = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (replica_sel_i == 2'd3) begin
            tgt_d = rot_q;
            rot_d = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
          end else begin
            tgt_d = replica_sel_i;
          end
          mode_d = mode_i;
          bit_d  = random_bit_i ? lfsr_q[BIT_W-1:0] : bit_sel_i;
          dur_d  = (duration_i == '0) ? DUR_W'(1) : duration_i;
          if (delay_i == '0) begin
            state_d      = S_INJECT;
            dcnt_d       = dur_d - DUR_W'(1);
            enter_inject = 1'b1;
          end else begin
            state_d = S_ARM;
            cnt_d   = delay_i - DELAY_W'(1);
          end
        end
      end
      S_ARM: begin
        if (abort_i) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d      = S_INJECT;
          dcnt_d       = dur_q - DUR_W'(1);
          enter_inject = 1'b1;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      S_INJECT: begin
        if (abort_i || dcnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_inject && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end

    busy_d   = (state_d != S_IDLE);
    active_d = (state_d == S_INJECT);
    done_d   = (state_d == S_DONE);
  end

  // State, campaign latches and registered status flags.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      dur_q    <= '0;
      tgt_q    <= 2'd0;
      mode_q   <= 2'd0;
      bit_q    <= '0;
      rot_q    <= 2'd0;
      lfsr_q   <= LFSR_SEED;
      count_q  <= 16'd0;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      dur_q    <= dur_d;
      tgt_q    <= tgt_d;
      mode_q   <= mode_d;
      bit_q    <= bit_d;
      rot_q    <= rot_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Replica datapath: only the latched target is touched, and only while injecting.
  always_comb begin
    A_o = (active_q && tgt_q == 2'd0) ? corrupt(A_i, mode_q, bit_q) : A_i;
    B_o = (active_q && tgt_q == 2'd1) ? corrupt(B_i, mode_q, bit_q) : B_i;
    C_o = (active_q && tgt_q == 2'd2) ? corrupt(C_i, mode_q, bit_q) : C_i;
  end

  assign busy_o         = busy_q;
  assign fault_active_o = active_q;
  assign done_o         = done_q;
  assign inject_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_fault_injector
// Brief    : Directed scoreboard bench for tmr_fault_injector. Each stimulus
//            cycle pushes its hand-derived expected outputs; a monitor pops
//            and compares one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_fault_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, rnd;
  logic [1:0]  sel, mode;
  logic [4:0]  bsel;
  logic [15:0] dly;
  logic [7:0]  dur;
  logic [31:0] a_i, b_i, c_i;
  logic [31:0] a_o, b_o, c_o;
  logic        busy, active, done;
  logic [15:0] icount;

  logic [31:0] base;
  logic [15:0] e_cnt;

  typedef struct {
    logic [31:0] a, b, c, base;
    logic        busy, act, done;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tmr_fault_injector #(
    .WIDTH(32), .DELAY_W(16), .DUR_W(8), .LFSR_SEED(32'hACE11234)
  ) dut (
    .clk           (clk),
    .sys_reset_i   (rst),
    .start_i       (start),
    .abort_i       (abort),
    .replica_sel_i (sel),
    .mode_i        (mode),
    .bit_sel_i     (bsel),
    .random_bit_i  (rnd),
    .delay_i       (dly),
    .duration_i    (dur),
    .A_i           (a_i),
    .B_i           (b_i),
    .C_i           (c_i),
    .A_o           (a_o),
    .B_o           (b_o),
    .C_o           (c_o),
    .busy_o        (busy),
    .fault_active_o(active),
    .done_o        (done),
    .inject_count_o(icount)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expected outputs.
  task automatic cyc(input logic st, input logic ab, input logic rs,
                     input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                     input logic ebusy, input logic eact, input logic edone);
    exp_t e;
    @(negedge clk);
    start = st;
    abort = ab;
    rst   = rs;
    a_i   = base;
    b_i   = base;
    c_i   = base;
    e.a = ea; e.b = eb; e.c = ec; e.base = base;
    e.busy = ebusy; e.act = eact; e.done = edone; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  task automatic idle(input logic st);
    cyc(st, 1'b0, 1'b0, base, base, base, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic arm(input logic ab);
    cyc(1'b0, ab, 1'b0, base, base, base, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic inj(input logic st, input logic ab, input logic [31:0] ea,
                     input logic [31:0] eb, input logic [31:0] ec);
    cyc(st, ab, 1'b0, ea, eb, ec, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic dn(input logic st);
    cyc(st, 1'b0, 1'b0, base, base, base, 1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    exp_t        e;
    logic [31:0] vote;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e    = q.pop_front();
        vote = (a_o & b_o) | (a_o & c_o) | (b_o & c_o);
        chk("A_o", a_o, e.a);
        chk("B_o", b_o, e.b);
        chk("C_o", c_o, e.c);
        chk("busy_o", {31'd0, busy}, {31'd0, e.busy});
        chk("fault_active_o", {31'd0, active}, {31'd0, e.act});
        chk("done_o", {31'd0, done}, {31'd0, e.done});
        chk("inject_count_o", {16'd0, icount}, {16'd0, e.cnt});
        chk("voter", vote, e.base);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rnd = 1'b0;
    sel = 2'd0; mode = 2'd0; bsel = 5'd0; dly = 16'd0; dur = 8'd0;
    base = 32'h1234_5678; a_i = base; b_i = base; c_i = base;
    e_cnt = 16'd0;
    repeat (2) @(negedge clk);

    // Reset state and idle pass-through.
    cyc(1'b0, 1'b0, 1'b1, base, base, base, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Replica B, bit-flip bit 4, delay 3, duration 2.
    sel = 2'd1; mode = 2'd0; bsel = 5'd4; dly = 16'd3; dur = 8'd2;
    idle(1'b1);
    arm(1'b0); arm(1'b0); arm(1'b0);
    e_cnt = 16'd1;
    inj(1'b0, 1'b0, base, 32'h1234_5668, base);
    inj(1'b0, 1'b0, base, 32'h1234_5668, base);
    dn(1'b0);
    idle(1'b0);

    // Replica A, stuck-at-1 bit 31, delay 0, duration 0 (one cycle).
    sel = 2'd0; mode = 2'd2; bsel = 5'd31; dly = 16'd0; dur = 8'd0;
    idle(1'b1);
    e_cnt = 16'd2;
    inj(1'b0, 1'b0, 32'h9234_5678, base, base);
    dn(1'b0);
    idle(1'b0);

    // Rotating target A -> B -> C; start during DONE is ignored.
    sel = 2'd3; mode = 2'd0; bsel = 5'd0; dly = 16'd0; dur = 8'd1;
    idle(1'b1);
    e_cnt = 16'd3;
    inj(1'b0, 1'b0, 32'h1234_5679, base, base);
    dn(1'b1);
    idle(1'b0);
    idle(1'b1);
    e_cnt = 16'd4;
    inj(1'b0, 1'b0, base, 32'h1234_5679, base);
    dn(1'b0);
    idle(1'b1);
    e_cnt = 16'd5;
    inj(1'b0, 1'b0, base, base, 32'h1234_5679);
    dn(1'b0);

    // Fourth rotation hits A; reset mid-INJECT, then the pointer restarts at A.
    dur = 8'd10;
    idle(1'b1);
    e_cnt = 16'd6;
    inj(1'b0, 1'b0, 32'h1234_5679, base, base);
    cyc(1'b0, 1'b0, 1'b1, 32'h1234_5679, base, base, 1'b1, 1'b1, 1'b0);
    e_cnt = 16'd0;
    idle(1'b0);
    dur = 8'd1;
    idle(1'b1);
    e_cnt = 16'd1;
    inj(1'b0, 1'b0, 32'h1234_5679, base, base);
    dn(1'b0);
    idle(1'b0);

    // Replica C, stuck-at-0 bit 5, 10-cycle INJECT aborted on its second cycle.
    base = 32'hA5A5_A5A5;
    sel = 2'd2; mode = 2'd1; bsel = 5'd5; dly = 16'd0; dur = 8'd10;
    idle(1'b1);
    e_cnt = 16'd2;
    inj(1'b0, 1'b0, base, base, 32'hA5A5_A585);
    inj(1'b1, 1'b1, base, base, 32'hA5A5_A585);
    dn(1'b1);
    idle(1'b0);
    cyc(1'b0, 1'b1, 1'b0, base, base, base, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Abort during ARM: no INJECT entry, counter unchanged.
    sel = 2'd1; mode = 2'd0; bsel = 5'd0; dly = 16'd5; dur = 8'd3;
    idle(1'b1);
    arm(1'b0);
    arm(1'b1);
    dn(1'b0);
    idle(1'b0);

    // Random bit straight after reset: seed 0xACE11234 selects bit 20 (mode 3 = flip).
    base = 32'h1234_5678;
    sel = 2'd0; mode = 2'd3; bsel = 5'd0; rnd = 1'b1; dly = 16'd0; dur = 8'd1;
    cyc(1'b0, 1'b0, 1'b1, base, base, base, 1'b0, 1'b0, 1'b0);
    e_cnt = 16'd0;
    idle(1'b1);
    e_cnt = 16'd1;
    inj(1'b0, 1'b0, 32'h1224_5678, base, base);
    dn(1'b0);
    idle(1'b0);
    rnd = 1'b0;

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d entries pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
